alu_ctrl: RTL and testbench



---
 rtl/alu_ctrl_pkg.sv | 22 ++
 rtl/alu_ctrl_stats.sv | 42 ++++
 rtl/alu_ctrl.sv | 152 +++++++++++++++
 tb/tb_alu_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sequencing stage: function codes, FSM states, datapath width.
// Used by alu_ctrl and, when ALU_CTRL_STATS_EN is defined, by alu_ctrl_stats.
package alu_ctrl_pkg;

  localparam int ALU_W = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/alu_ctrl_stats.sv
// Saturating retirement and overflow counters for alu_ctrl.
// Only instantiated when ALU_CTRL_STATS_EN is defined.
module alu_ctrl_stats
  import alu_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             retire,
  input  logic             ovf,
  output logic [CNT_W-1:0] stat_ops,
  output logic [CNT_W-1:0] stat_ovf
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] ops_q, ops_d;
  logic [CNT_W-1:0] ovf_q, ovf_d;

  // Both counters stick at all-ones instead of wrapping.
  always_comb begin
    ops_d = ops_q;
    ovf_d = ovf_q;
    if (retire && (ops_q != '1)) ops_d = ops_q + CNT_ONE;
    if (retire && ovf && (ovf_q != '1)) ovf_d = ovf_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ops_q <= '0;
      ovf_q <= '0;
    end else begin
      ops_q <= ops_d;
      ovf_q <= ovf_d;
    end
  end

  assign stat_ops = ops_q;
  assign stat_ovf = ovf_q;

endmodule

// File: rtl/alu_ctrl.sv
// Sequencing stage in front of the 4-bit ALU: accept op, drive ALU for one cycle, hold result.
// Optional statistics counters are enabled by defining ALU_CTRL_STATS_EN.
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter logic [ALU_W-1:0] ACC_INIT = 4'h0
`ifdef ALU_CTRL_STATS_EN
  ,
  parameter int CNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic [ALU_W-1:0] in_a,
  input  logic [ALU_W-1:0] in_b,
  output logic [2:0]       alu_fnselec,
  output logic [ALU_W-1:0] alu_a,
  output logic [ALU_W-1:0] alu_b,
  input  logic [ALU_W-1:0] alu_res,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ALU_W-1:0] out_res,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_carry,
  output logic [ALU_W-1:0] acc
`ifdef ALU_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_ops,
  output logic [CNT_W-1:0] stat_ovf
`endif
);

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [ALU_W-1:0] a_q, a_d;
  logic [ALU_W-1:0] b_q, b_d;
  logic [ALU_W-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             carry_q, carry_d;
  logic             valid_q, valid_d;
  logic [ALU_W-1:0] acc_q, acc_d;

  // Accepting from HOLD reads acc_q, which already holds the retiring result.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    carry_d  = carry_q;
    valid_d  = valid_q;
    acc_d    = acc_q;
    in_ready = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_d    = in_op;
          a_d     = in_acc ? acc_q : in_a;
          b_d     = in_b;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_res;
        zero_d  = alu_zero;
        ovf_d   = alu_overflow;
        carry_d = alu_carry;
        acc_d   = alu_res;
        valid_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        in_ready = out_ready;
        if (out_ready) begin
          valid_d = 1'b0;
          if (in_valid) begin
            op_d    = in_op;
            a_d     = in_acc ? acc_q : in_a;
            b_d     = in_b;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
      acc_q   <= ACC_INIT;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
      acc_q   <= acc_d;
    end
  end

  assign alu_fnselec = op_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign out_valid   = valid_q;
  assign out_res     = res_q;
  assign out_zero    = zero_q;
  assign out_ovf     = ovf_q;
  assign out_carry   = carry_q;
  assign acc         = acc_q;

`ifdef ALU_CTRL_STATS_EN
  alu_ctrl_stats #(
    .CNT_W(CNT_W)
  ) u_stats (
    .clk     (clk),
    .rst     (rst),
    .retire  (valid_q & out_ready),
    .ovf     (ovf_q),
    .stat_ops(stat_ops),
    .stat_ovf(stat_ovf)
  );
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed self-checking bench for alu_ctrl, wired to a behavioural 4-bit ALU.
// Statistics checks are compiled in when ALU_CTRL_STATS_EN is defined.
`timescale 1ns/1ps
module tb_alu_ctrl;
  import alu_ctrl_pkg::*;

  localparam logic [3:0] ACC_INIT_TB = 4'h0;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic       in_acc;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [2:0] alu_fnselec;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_res;
  logic       alu_zero;
  logic       alu_overflow;
  logic       alu_carry;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_res;
  logic       out_zero;
  logic       out_ovf;
  logic       out_carry;
  logic [3:0] acc;
`ifdef ALU_CTRL_STATS_EN
  logic [7:0] stat_ops;
  logic [7:0] stat_ovf;
`endif

  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  // Behavioural ALU: carry is carry-out (no-borrow for subtract), zero only for add/sub.
  logic [4:0] sum5;
  always_comb begin
    sum5         = 5'd0;
    alu_res      = 4'h0;
    alu_zero     = 1'b0;
    alu_overflow = 1'b0;
    alu_carry    = 1'b0;
    case (alu_fnselec)
      OP_ADD: begin
        sum5         = {1'b0, alu_a} + {1'b0, alu_b};
        alu_res      = sum5[3:0];
        alu_carry    = sum5[4];
        alu_overflow = (alu_a[3] == alu_b[3]) && (sum5[3] != alu_a[3]);
        alu_zero     = (sum5[3:0] == 4'h0);
      end
      OP_SUB: begin
        sum5         = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
        alu_res      = sum5[3:0];
        alu_carry    = sum5[4];
        alu_overflow = (alu_a[3] != alu_b[3]) && (sum5[3] != alu_a[3]);
        alu_zero     = (sum5[3:0] == 4'h0);
      end
      OP_AND: alu_res = alu_a & alu_b;
      OP_OR:  alu_res = alu_a | alu_b;
      OP_XOR: alu_res = alu_a ^ alu_b;
      OP_NOR: alu_res = ~(alu_a | alu_b);
      OP_SLT: alu_res = {3'b000, ($signed(alu_a) < $signed(alu_b))};
      OP_EQ:  alu_res = {3'b000, (alu_a == alu_b)};
      default: alu_res = 4'h0;
    endcase
  end

  alu_ctrl #(
    .ACC_INIT(ACC_INIT_TB)
`ifdef ALU_CTRL_STATS_EN
    ,
    .CNT_W(8)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_acc      (in_acc),
    .in_a        (in_a),
    .in_b        (in_b),
    .alu_fnselec (alu_fnselec),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_res     (alu_res),
    .alu_zero    (alu_zero),
    .alu_overflow(alu_overflow),
    .alu_carry   (alu_carry),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_res     (out_res),
    .out_zero    (out_zero),
    .out_ovf     (out_ovf),
    .out_carry   (out_carry),
    .acc         (acc)
`ifdef ALU_CTRL_STATS_EN
    ,
    .stat_ops    (stat_ops),
    .stat_ovf    (stat_ovf)
`endif
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one operation for a single edge, then drops in_valid; leaves signals #1 after the edge.
  task automatic applyStimulus(input logic [2:0] op, input logic useAcc, input logic [3:0] a, input logic [3:0] b);
    in_op    = op;
    in_acc   = useAcc;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 3'b000;
    in_acc    = 1'b0;
    in_a      = 4'h0;
    in_b      = 4'h0;
    out_ready = 1'b1;
    stepCycle();
    stepCycle();
    rst = 1'b0;

    checkOutput("rst_out_valid", {7'd0, out_valid}, 8'h00);
    checkOutput("rst_out_res", {4'd0, out_res}, 8'h00);
    checkOutput("rst_flags", {5'd0, out_zero, out_ovf, out_carry}, 8'h00);
    checkOutput("rst_acc", {4'd0, acc}, {4'd0, ACC_INIT_TB});
    checkOutput("rst_in_ready", {7'd0, in_ready}, 8'h01);
    checkOutput("rst_alu_drive", {1'b0, alu_fnselec, alu_a}, 8'h00);

    // Add 7+1: signed overflow, no carry.
    applyStimulus(OP_ADD, 1'b0, 4'h7, 4'h1);
    checkOutput("add_exec_valid", {7'd0, out_valid}, 8'h00);
    checkOutput("add_exec_ready", {7'd0, in_ready}, 8'h00);
    checkOutput("add_exec_drive", {1'b0, alu_fnselec, alu_a}, 8'h07);
    checkOutput("add_exec_b", {4'd0, alu_b}, 8'h01);
    stepCycle();
    checkOutput("add_valid", {7'd0, out_valid}, 8'h01);
    checkOutput("add_res", {4'd0, out_res}, 8'h08);
    checkOutput("add_flags_zoc", {5'd0, out_zero, out_ovf, out_carry}, 8'h02);
    checkOutput("add_acc", {4'd0, acc}, 8'h08);
    checkOutput("add_hold_ready", {7'd0, in_ready}, 8'h01);
    stepCycle();
    checkOutput("retire_idle_valid", {7'd0, out_valid}, 8'h00);
    checkOutput("retire_idle_ready", {7'd0, in_ready}, 8'h01);

    // Subtract 3-5 = E with borrow (carry=0).
    applyStimulus(OP_SUB, 1'b0, 4'h3, 4'h5);
    stepCycle();
    checkOutput("sub_res", {4'd0, out_res}, 8'h0E);
    checkOutput("sub_flags_zoc", {5'd0, out_zero, out_ovf, out_carry}, 8'h00);
    checkOutput("sub_acc", {4'd0, acc}, 8'h0E);

    // Add 4+4 issued back-to-back from HOLD.
    applyStimulus(OP_ADD, 1'b0, 4'h4, 4'h4);
    checkOutput("b2b_exec_valid", {7'd0, out_valid}, 8'h00);
    stepCycle();
    checkOutput("add44_res", {4'd0, out_res}, 8'h08);
    checkOutput("add44_acc", {4'd0, acc}, 8'h08);

    // Chain: acc(8)+8, in_a must be ignored.
    applyStimulus(OP_ADD, 1'b1, 4'hF, 4'h8);
    checkOutput("chain_alu_a", {4'd0, alu_a}, 8'h08);
    stepCycle();
    checkOutput("chain_res", {4'd0, out_res}, 8'h00);
    checkOutput("chain_flags_zoc", {5'd0, out_zero, out_ovf, out_carry}, 8'h07);
    checkOutput("chain_acc", {4'd0, acc}, 8'h00);
    stepCycle();

    // Backpressure on an equal op; in_valid during HOLD must be ignored.
    out_ready = 1'b0;
    applyStimulus(OP_EQ, 1'b0, 4'h5, 4'h5);
    stepCycle();
    in_op    = OP_ADD;
    in_a     = 4'h1;
    in_b     = 4'h1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("bp_valid_%0d", i), {7'd0, out_valid}, 8'h01);
      checkOutput($sformatf("bp_res_%0d", i), {4'd0, out_res}, 8'h01);
      checkOutput($sformatf("bp_ready_%0d", i), {7'd0, in_ready}, 8'h00);
      stepCycle();
    end
    checkOutput("bp_flags_zoc", {5'd0, out_zero, out_ovf, out_carry}, 8'h00);
    checkOutput("bp_ignored_a", {4'd0, alu_a}, 8'h05);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    stepCycle();
    checkOutput("bp_release_valid", {7'd0, out_valid}, 8'h00);
    checkOutput("bp_release_ready", {7'd0, in_ready}, 8'h01);
    checkOutput("bp_acc", {4'd0, acc}, 8'h01);

    // Reset during EXEC discards the operation.
    applyStimulus(OP_OR, 1'b0, 4'hF, 4'h3);
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkOutput("rstexec_valid", {7'd0, out_valid}, 8'h00);
    checkOutput("rstexec_acc", {4'd0, acc}, {4'd0, ACC_INIT_TB});
    checkOutput("rstexec_ready", {7'd0, in_ready}, 8'h01);
    checkOutput("rstexec_res", {4'd0, out_res}, 8'h00);
    checkOutput("rstexec_alu_a", {4'd0, alu_a}, 8'h00);

`ifdef ALU_CTRL_STATS_EN
    checkOutput("stat_clear_ops", stat_ops, 8'd0);
    applyStimulus(OP_ADD, 1'b0, 4'h1, 4'h1);
    stepCycle();
    applyStimulus(OP_ADD, 1'b0, 4'h7, 4'h7);
    stepCycle();
    applyStimulus(OP_SUB, 1'b0, 4'h2, 4'h1);
    stepCycle();
    stepCycle();
    checkOutput("stat_ops_3", stat_ops, 8'd3);
    checkOutput("stat_ovf_1", stat_ovf, 8'd1);
    for (int i = 0; i < 260; i++) begin
      applyStimulus(OP_ADD, 1'b0, 4'h7, 4'h7);
      stepCycle();
    end
    stepCycle();
    checkOutput("stat_ops_sat", stat_ops, 8'hFF);
    checkOutput("stat_ovf_sat", stat_ovf, 8'hFF);
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
